// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencing controller: default sizes and the
// controller state encoding.
package mac_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int NUM_ROWS_DEF   = 8;
   localparam int RD_WIDTH       = 64;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      UNPACK,
      CLR,
      FEED,
      DRAIN,
      DONE
   } state_e;

endpackage

// File: rtl/byte_unpacker.sv
// Holds one Avalon read word and steps through its bytes, least significant
// byte first, one byte per accepted write.
module byte_unpacker
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NUM_ROWS   = NUM_ROWS_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [RD_WIDTH-1:0]   load_data,
   input  logic                  advance,
   output logic [DATA_WIDTH-1:0] byte_out,
   output logic                  last
);

   localparam int CNT_W = $clog2(NUM_ROWS - 1) + 1;

   logic [RD_WIDTH-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   assign last = (cnt_q == CNT_W'(NUM_ROWS - 1));

   // The counter stops on the last byte; the next load restarts it.
   always_comb begin
      hold_d = hold_q;
      cnt_d  = cnt_q;
      if (load) begin
         hold_d = load_data;
         cnt_d  = '0;
      end else if (advance && !last) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      byte_out = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (cnt_q == CNT_W'(i)) byte_out = hold_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         cnt_q  <= '0;
      end else begin
         hold_q <= hold_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Fetches NUM_ROWS+1 words over Avalon-MM, scatters their bytes into the B FIFO
// (word 0) and A FIFOs (words 1..NUM_ROWS), then clears, feeds and drains the MACs.
module mac_seq_ctrl
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int NUM_ROWS     = NUM_ROWS_DEF,
   parameter int DRAIN_CYCLES = NUM_ROWS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           address,
   output logic                  read,
   input  logic [RD_WIDTH-1:0]   readdata,
   input  logic                  readdatavalid,
   input  logic                  waitrequest,
   output logic [DATA_WIDTH-1:0] fifo_wdata,
   output logic [NUM_ROWS:0]     fifo_wrreq,
   input  logic [NUM_ROWS:0]     fifo_wrfull,
   output logic                  mac_clr,
   output logic                  mac_en
);

   localparam int WORD_W = $clog2(NUM_ROWS) + 1;
   localparam int PH_MAX = ((NUM_ROWS > DRAIN_CYCLES) ? NUM_ROWS : DRAIN_CYCLES) - 1;
   localparam int PH_W   = $clog2(PH_MAX) + 1;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [PH_W-1:0]     ph_q, ph_d;
   logic [NUM_ROWS:0]   sel;
   logic                tgt_full;
   logic                load;
   logic                advance;
   logic                byte_last;
   logic [DATA_WIDTH-1:0] byte_cur;

   byte_unpacker #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_ROWS   (NUM_ROWS)
   ) u_unpacker (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (readdata),
      .advance   (advance),
      .byte_out  (byte_cur),
      .last      (byte_last)
   );

   // Word 0 targets the B FIFO (top bit); word w targets A FIFO w-1.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_ROWS; i++) sel[i] = (word_q == WORD_W'(i + 1));
      sel[NUM_ROWS] = (word_q == '0);
   end

   assign tgt_full = |(sel & fifo_wrfull);
   assign busy     = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      ph_d       = ph_q;
      load       = 1'b0;
      advance    = 1'b0;
      read       = 1'b0;
      address    = '0;
      fifo_wdata = '0;
      fifo_wrreq = '0;
      mac_clr    = 1'b0;
      mac_en     = 1'b0;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               word_d  = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            read    = 1'b1;
            address = {{(32-WORD_W){1'b0}}, word_q};
            if (!waitrequest) state_d = WAIT;
         end
         WAIT: begin
            if (readdatavalid) begin
               load    = 1'b1;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            fifo_wdata = byte_cur;
            // A full target stalls in place: no strobe, counter held.
            if (!tgt_full) begin
               fifo_wrreq = sel;
               advance    = 1'b1;
               if (byte_last) begin
                  if (word_q < WORD_W'(NUM_ROWS)) begin
                     word_d  = word_q + 1'b1;
                     state_d = REQ;
                  end else begin
                     state_d = CLR;
                  end
               end
            end
         end
         CLR: begin
            mac_clr = 1'b1;
            ph_d    = '0;
            state_d = FEED;
         end
         FEED: begin
            mac_en = 1'b1;
            if (ph_q == PH_W'(NUM_ROWS - 1)) begin
               ph_d    = '0;
               state_d = DRAIN;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         DRAIN: begin
            if (DRAIN_CYCLES == 0 || ph_q == PH_W'(DRAIN_CYCLES - 1)) begin
               ph_d    = '0;
               state_d = DONE;
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         ph_q    <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         ph_q    <= ph_d;
      end
   end

endmodule
